tree_lane_loader: RTL and testbench

//  Serial-to-parallel front end for the reduction tree.
//  - Accepts one LEN-bit word per valid/ready beat.
//  - Packs NUM words into the flat NUM*LEN lane vector that the tree consumes.
//  - Presents the vector with a valid/ready output handshake.
//  - Sits between the narrow stream source and the tree's wide `in` bus; the tree's select reduction runs downstream.

---
 rtl/tree_lane_loader.sv | 135 +++++++++++++
 tb/tb_tree_lane_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_lane_loader.sv
// tree_lane_loader: packs a stream of LEN-bit words into NUM-lane frames for the reduction tree.
// Optional macro TREE_LOADER_DOUBLE_BUF_EN adds a shadow fill buffer so frame N+1 loads while frame N is held.
module tree_lane_loader #(
    parameter int unsigned NUM      = 4096,
    parameter int unsigned LEN      = 16,
    parameter int unsigned PAD_ONES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LEN-1:0]           in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM*LEN-1:0]       out_data,
    output logic [$clog2(NUM+1)-1:0] out_count
);

    localparam int unsigned CW = $clog2(NUM + 1);
    localparam logic [LEN-1:0] PAD = (PAD_ONES != 0) ? {LEN{1'b1}} : {LEN{1'b0}};
    localparam logic [NUM*LEN-1:0] PAD_ALL = {NUM{PAD}};

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t             state;
    logic               alive;  // keeps in_ready low until the first edge after reset release
    logic [CW-1:0]      lane_cnt;
    logic               in_beat_c;
    logic               out_beat_c;
    logic               frame_done_c;
    logic [CW-1:0]      cnt_next_c;
    logic [NUM*LEN-1:0] fill_base_c;
    logic [NUM*LEN-1:0] fill_next_c;

    assign in_beat_c    = in_valid && in_ready;
    assign out_beat_c   = out_valid && out_ready;
    assign cnt_next_c   = lane_cnt + CW'(in_beat_c);
    assign frame_done_c = in_beat_c && (in_last || (lane_cnt == CW'(NUM - 1)));

    // Fill buffer with the current word dropped into lane lane_cnt.
    for (genvar k = 0; k < NUM; k++) begin : g_lane
        assign fill_next_c[k*LEN +: LEN] = (in_beat_c && (lane_cnt == CW'(k)))
                                         ? in_data : fill_base_c[k*LEN +: LEN];
    end

`ifdef TREE_LOADER_DOUBLE_BUF_EN
    logic [NUM*LEN-1:0] fb_data;
    logic               fb_done;
    logic               out_free_c;

    assign in_ready    = alive && !fb_done;
    assign fill_base_c = fb_data;
    assign out_free_c  = (state == FILL) || out_beat_c;

    // A completed fill buffer moves to the output register whenever that register is free this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            alive     <= 1'b0;
            lane_cnt  <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_data  <= PAD_ALL;
            fb_data   <= PAD_ALL;
            fb_done   <= 1'b0;
        end else begin
            alive <= 1'b1;
            if ((frame_done_c || fb_done) && out_free_c) begin
                state     <= HOLD;
                out_valid <= 1'b1;
                out_data  <= fill_next_c;
                out_count <= cnt_next_c;
                fb_data   <= PAD_ALL;
                lane_cnt  <= '0;
                fb_done   <= 1'b0;
            end else begin
                fb_data  <= fill_next_c;
                lane_cnt <= cnt_next_c;
                fb_done  <= fb_done || frame_done_c;
                if (out_beat_c) begin
                    state     <= FILL;
                    out_valid <= 1'b0;
                    out_count <= '0;
                    out_data  <= PAD_ALL;
                end
            end
        end
    end
`else
    assign in_ready    = alive && (state == FILL);
    assign fill_base_c = out_data;

    // The output register doubles as the fill buffer; it is frozen while a frame is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            alive     <= 1'b0;
            lane_cnt  <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_data  <= PAD_ALL;
        end else begin
            alive <= 1'b1;
            case (state)
                FILL: begin
                    if (in_beat_c) begin
                        out_data <= fill_next_c;
                        lane_cnt <= cnt_next_c;
                        if (frame_done_c) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_count <= cnt_next_c;
                        end
                    end
                end
                HOLD: begin
                    if (out_beat_c) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        out_count <= '0;
                        lane_cnt  <= '0;
                        out_data  <= PAD_ALL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_tree_lane_loader.sv
// Scoreboard bench for tree_lane_loader (NUM=4, LEN=8), one instance per PAD_ONES setting on shared stimulus.
module tb_tree_lane_loader;

    localparam int NUM = 4;
    localparam int LEN = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic [LEN-1:0]  in_data;
    logic            in_last;
    logic            out_ready;
    logic            in_ready1, in_ready0;
    logic            out_valid1, out_valid0;
    logic [31:0]     out_data1, out_data0;
    logic [2:0]      out_count1, out_count0;

    int checks = 0;
    int errors = 0;
    int frames_pushed = 0;
    int frames_seen = 0;
    bit rnd_ready = 0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d0;
        int          cnt;
    } exp_t;

    exp_t           exp_q[$];
    logic [LEN-1:0] words[$];

    logic        pv, pr;
    logic [31:0] pd;
    logic [2:0]  pc;

    always #5 clk = ~clk;

    tree_lane_loader #(.NUM(NUM), .LEN(LEN), .PAD_ONES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_count(out_count1)
    );

    tree_lane_loader #(.NUM(NUM), .LEN(LEN), .PAD_ONES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_count(out_count0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: collect accepted words, emit a frame on in_last or a full frame.
    task automatic model_push(input logic [LEN-1:0] d, input logic l);
        exp_t e;
        words.push_back(d);
        if (l || words.size() == NUM) begin
            e.d1 = '1;
            e.d0 = '0;
            for (int k = 0; k < words.size(); k++) begin
                e.d1[k*LEN +: LEN] = words[k];
                e.d0[k*LEN +: LEN] = words[k];
            end
            e.cnt = words.size();
            exp_q.push_back(e);
            frames_pushed++;
            words.delete();
        end
    endtask

    task automatic send(input logic [LEN-1:0] d, input logic l, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waited   = 0;
        while (!in_ready1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_push(d, l);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 out_ready = r;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while ((exp_q.size() != 0 || out_valid1) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d frames pending, required 0", exp_q.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: protocol stability while stalled, scoreboard compare on every output beat.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("hold_valid", 64'(out_valid1), 64'd1);
                check("hold_data", 64'(out_data1), 64'(pd));
                check("hold_count", 64'(out_count1), 64'(pc));
            end
            if (out_valid1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %0h expected none", out_data1);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_data_pad1", 64'(out_data1), 64'(e.d1));
                    check("frame_data_pad0", 64'(out_data0), 64'(e.d0));
                    check("frame_count", 64'(out_count1), 64'(e.cnt));
                    check("frame_count_pad0", 64'(out_count0), 64'(e.cnt));
                    check("frame_valid_pad0", 64'(out_valid0), 64'd1);
                    frames_seen++;
                end
            end
            pv = out_valid1;
            pr = out_ready;
            pd = out_data1;
            pc = out_count1;
        end
    end

    initial begin
        int len;
        logic l;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid1), 64'd0);
        check("rst_count", 64'(out_count1), 64'd0);
        check("rst_data_pad1", 64'(out_data1), 64'hFFFFFFFF);
        check("rst_data_pad0", 64'(out_data0), 64'h0);
        rst_n = 1'b1;
        #1 check("ready_at_release", 64'(in_ready1), 64'd0);
        @(negedge clk);
        check("ready_after_release", 64'(in_ready1), 64'd1);

        // Full frame held under backpressure
        send(8'h11, 1'b0, 0);
        send(8'h22, 1'b0, 0);
        send(8'h33, 1'b0, 0);
        send(8'h44, 1'b0, 0);
        @(negedge clk);
        check("full_valid", 64'(out_valid1), 64'd1);
        check("full_data", 64'(out_data1), 64'h44332211);
        check("full_count", 64'(out_count1), 64'd4);
`ifdef TREE_LOADER_DOUBLE_BUF_EN
        check("full_ready", 64'(in_ready1), 64'd1);
`else
        check("full_ready", 64'(in_ready1), 64'd0);
`endif
        repeat (5) @(negedge clk);
        check("hold_after5", 64'(out_data1), 64'h44332211);
        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        check("post_beat_valid", 64'(out_valid1), 64'd0);
        check("post_beat_pad1", 64'(out_data1), 64'hFFFFFFFF);
        check("post_beat_pad0", 64'(out_data0), 64'h0);

        // Short frame padded
        set_ready(1'b0);
        send(8'h05, 1'b0, 0);
        send(8'h07, 1'b1, 0);
        @(negedge clk);
        check("short_data_pad1", 64'(out_data1), 64'hFFFF0705);
        check("short_data_pad0", 64'(out_data0), 64'h00000705);
        check("short_count", 64'(out_count1), 64'd2);
        set_ready(1'b1);
        wait_drain();

        // Reset mid-frame discards the partial frame
        send(8'hA1, 1'b0, 0);
        send(8'hA2, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        words.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hB1, 1'b0, 0);
        send(8'hB2, 1'b0, 0);
        send(8'hB3, 1'b0, 0);
        send(8'hB4, 1'b0, 0);
        @(negedge clk);
        check("after_reset_data", 64'(out_data1), 64'hB4B3B2B1);
        wait_drain();

`ifdef TREE_LOADER_DOUBLE_BUF_EN
        // Two frames queued behind backpressure
        set_ready(1'b0);
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 0);
        @(negedge clk);
        check("dbuf_ready_full", 64'(in_ready1), 64'd0);
        check("dbuf_first", 64'(out_data1), 64'h04030201);
        set_ready(1'b1);
        @(posedge clk);
        @(negedge clk);
        check("dbuf_second_valid", 64'(out_valid1), 64'd1);
        check("dbuf_second", 64'(out_data1), 64'h08070605);
        @(posedge clk);
        @(negedge clk);
        check("dbuf_drained", 64'(out_valid1), 64'd0);
`endif

        // Random stalls and frame lengths
        rnd_ready = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, NUM);
            for (int i = 0; i < len; i++) begin
                if (i == len - 1) l = (len < NUM) ? 1'b1 : 1'($urandom);
                else l = 1'b0;
                send(8'($urandom), l, $urandom_range(0, 2));
            end
        end
        rnd_ready = 1'b0;
        set_ready(1'b1);
        wait_drain();
        repeat (2) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("frames_seen", 64'(frames_seen), 64'(frames_pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
